// File: rtl/ee354_numlock_if.sv
// Button inputs and lock status outputs of the parametrised number lock.
// master drives the buttons (button debouncer side); slave is the lock FSM.
interface ee354_numlock_if #(
  parameter int unsigned CODE_LEN  = 4,
  parameter int unsigned MAX_FAILS = 3
);
  localparam int unsigned DigitW = $clog2(CODE_LEN + 1);
  localparam int unsigned FailW  = $clog2(MAX_FAILS + 1);

  logic              U;
  logic              Z;
  logic              Unlock;
  logic              q_Bad;
  logic              q_Lockout;
  logic [2:0]        state;
  logic [DigitW-1:0] digit_cnt;
  logic [FailW-1:0]  fail_cnt;

  modport master (
    output U, Z,
    input  Unlock, q_Bad, q_Lockout, state, digit_cnt, fail_cnt
  );

  modport slave (
    input  U, Z,
    output Unlock, q_Bad, q_Lockout, state, digit_cnt, fail_cnt
  );
endinterface

// File: rtl/ee354_numlock_param_sm.sv
// U/Z number lock: collects a full CODE_LEN-digit entry before judging it,
// then pulses Unlock for OPEN_CYCLES or counts a failure, locking out after MAX_FAILS.
module ee354_numlock_param_sm #(
  parameter int unsigned          CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0]  CODE           = 4'b1011,
  parameter int unsigned          OPEN_CYCLES    = 16,
  parameter int unsigned          MAX_FAILS      = 3,
  parameter int unsigned          LOCKOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  ee354_numlock_if.slave     bus
);
  localparam int unsigned DigitW   = $clog2(CODE_LEN + 1);
  localparam int unsigned FailW    = $clog2(MAX_FAILS + 1);
  localparam int unsigned TimerMax = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES
                                                                    : LOCKOUT_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  localparam logic [DigitW-1:0] DigitMax  = DigitW'(CODE_LEN);
  localparam logic [FailW-1:0]  FailMax   = FailW'(MAX_FAILS);
  localparam logic [TimerW-1:0] OpenLoad  = TimerW'(OPEN_CYCLES - 1);
  localparam logic [TimerW-1:0] LockLoad  = TimerW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPress   = 3'd1,
    StWait    = 3'd2,
    StOpening = 3'd3,
    StBad     = 3'd4,
    StLockout = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [DigitW-1:0]   digit_cnt_q, digit_cnt_d;
  logic [FailW-1:0]    fail_cnt_q, fail_cnt_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                mismatch_q, mismatch_d;
  logic [CODE_LEN-1:0] code_shift;
  logic                any_btn;
  logic                digit_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      digit_cnt_q <= '0;
      fail_cnt_q  <= '0;
      timer_q     <= '0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      digit_cnt_q <= digit_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      timer_q     <= timer_d;
      mismatch_q  <= mismatch_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    digit_cnt_d = digit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    timer_d     = timer_q;
    mismatch_d  = mismatch_q;
    any_btn     = bus.U | bus.Z;
    // Expected digit for this position sits in the MSB after shifting out accepted digits.
    code_shift  = CODE << digit_cnt_q;
    digit_bad   = (bus.U == bus.Z) || (bus.U != code_shift[CODE_LEN-1]);

    case (state_q)
      StIdle, StWait: begin
        if (any_btn && (digit_cnt_q != DigitMax)) begin
          state_d     = StPress;
          digit_cnt_d = digit_cnt_q + 1'b1;
          mismatch_d  = mismatch_q | digit_bad;
        end
      end
      StPress: begin
        if (!any_btn) begin
          if (digit_cnt_q != DigitMax) begin
            state_d = StWait;
          end else begin
            digit_cnt_d = '0;
            mismatch_d  = 1'b0;
            if (mismatch_q) begin
              state_d    = StBad;
              fail_cnt_d = (fail_cnt_q == FailMax) ? fail_cnt_q : fail_cnt_q + 1'b1;
            end else begin
              state_d    = StOpening;
              fail_cnt_d = '0;
              timer_d    = OpenLoad;
            end
          end
        end
      end
      StOpening: begin
        if (timer_q == '0) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StBad: begin
        // fail_cnt was already incremented on entry.
        if (fail_cnt_q == FailMax) begin
          state_d = StLockout;
          timer_d = LockLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StLockout: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (!any_btn) begin
          state_d    = StIdle;
          fail_cnt_d = '0;
        end
      end
      default: begin
        state_d     = StIdle;
        digit_cnt_d = '0;
        mismatch_d  = 1'b0;
        timer_d     = '0;
      end
    endcase
  end

  assign bus.Unlock    = (state_q == StOpening);
  assign bus.q_Bad     = (state_q == StBad);
  assign bus.q_Lockout = (state_q == StLockout);
  assign bus.state     = state_q;
  assign bus.digit_cnt = digit_cnt_q;
  assign bus.fail_cnt  = fail_cnt_q;
endmodule

// File: tb/tb_ee354_numlock_param_sm.sv
// Scoreboard bench for the number lock: stimulus queues expected Unlock/Bad/Lockout
// pulse widths, a negedge monitor measures each pulse and compares in order.
module tb_ee354_numlock_param_sm;
  localparam int EvOpen = 0;
  localparam int EvBad  = 1;
  localparam int EvLock = 2;

  typedef struct {
    int kind;
    int len;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_fail = 0;
  ev_t  exp_q[$];

  ee354_numlock_if #(.CODE_LEN(4), .MAX_FAILS(3)) bus ();

  ee354_numlock_param_sm #(
    .CODE_LEN      (4),
    .CODE          (4'b1011),
    .OPEN_CYCLES   (16),
    .MAX_FAILS     (3),
    .LOCKOUT_CYCLES(64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int len);
    ev_t e;
    e.kind = kind;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  task automatic report(input int kind, input int len);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected event: kind %0d len %0d, required none", kind, len);
    end else begin
      e = exp_q.pop_front();
      check("event kind", kind, e.kind);
      check("event length", len, e.len);
    end
  endtask

  // One digit: 5 clocks held, 3 released.
  task automatic press(input logic u, input logic z);
    bus.U = u;
    bus.Z = z;
    repeat (5) @(posedge clk);
    #1;
    bus.U = 1'b0;
    bus.Z = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic [3:0] u, input logic [3:0] z, input bit good,
                       input string tag);
    if (good) expect_ev(EvOpen, 16);
    else      expect_ev(EvBad, 1);
    for (int i = 0; i < 4; i++) begin
      press(u[3-i], z[3-i]);
      if (i < 3) begin
        check({tag, " state WAIT"}, int'(bus.state), 2);
        check({tag, " digit_cnt"}, int'(bus.digit_cnt), i + 1);
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
      if (bus.state == 3'd0) done = 1'b1;
    end
    check({tag, " idle reached"}, int'(done), 1);
  endtask

  // Monitor: measures each high run of Unlock, q_Bad and q_Lockout.
  initial begin
    int open_len;
    int bad_len;
    int lock_len;
    open_len = 0;
    bad_len  = 0;
    lock_len = 0;
    forever begin
      @(negedge clk);
      if (bus.Unlock) open_len++;
      else if (open_len != 0) begin
        report(EvOpen, open_len);
        open_len = 0;
      end
      if (bus.q_Bad) bad_len++;
      else if (bad_len != 0) begin
        report(EvBad, bad_len);
        bad_len = 0;
      end
      if (bus.q_Lockout) lock_len++;
      else if (lock_len != 0) begin
        report(EvLock, lock_len);
        lock_len = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    reset = 1'b1;
    bus.U = 1'b0;
    bus.Z = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset state", int'(bus.state), 0);
    check("reset digit_cnt", int'(bus.digit_cnt), 0);
    check("reset fail_cnt", int'(bus.fail_cnt), 0);
    check("reset Unlock", int'(bus.Unlock), 0);
    check("reset q_Bad", int'(bus.q_Bad), 0);
    check("reset q_Lockout", int'(bus.q_Lockout), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Correct code opens for 16 clocks.
    enter(4'b1011, 4'b0100, 1'b1, "t1");
    wait_idle("t1");
    check("t1 fail_cnt", int'(bus.fail_cnt), 0);

    // Wrong last digit.
    enter(4'b1010, 4'b0101, 1'b0, "t2");
    wait_idle("t2");
    exp_fail = 1;
    check("t2 fail_cnt", int'(bus.fail_cnt), exp_fail);

    // Wrong first digit still collects all four digits.
    enter(4'b0011, 4'b1100, 1'b0, "t3");
    wait_idle("t3");
    exp_fail = 2;
    check("t3 fail_cnt", int'(bus.fail_cnt), exp_fail);

    enter(4'b1011, 4'b0100, 1'b1, "t3 good");
    wait_idle("t3 good");
    exp_fail = 0;
    check("t3 good fail_cnt", int'(bus.fail_cnt), exp_fail);

    // Three bad entries lock out; buttons ignored, a held button extends the lockout.
    for (int k = 0; k < 3; k++) begin
      enter(4'b1010, 4'b0101, 1'b0, "t4 bad");
      exp_fail++;
      if (k < 2) begin
        wait_idle("t4 bad");
        check("t4 fail_cnt", int'(bus.fail_cnt), exp_fail);
      end
    end
    // 64 minimum plus 10 clocks of the held U beyond expiry.
    expect_ev(EvLock, 74);
    check("t4 lockout fail_cnt", int'(bus.fail_cnt), 3);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("t4 lockout ignores digits", int'(bus.digit_cnt), 0);
    check("t4 still lockout", int'(bus.state), 5);
    bus.U = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("t4 held U extends lockout", int'(bus.state), 5);
    bus.U = 1'b0;
    wait_idle("t4 exit");
    exp_fail = 0;
    check("t4 exit fail_cnt", int'(bus.fail_cnt), exp_fail);
    enter(4'b1011, 4'b0100, 1'b1, "t4 good");
    wait_idle("t4 good");
    check("t4 good fail_cnt", int'(bus.fail_cnt), 0);

    // U and Z together is a wrong digit.
    enter(4'b1011, 4'b1100, 1'b0, "t5");
    wait_idle("t5");
    check("t5 fail_cnt", int'(bus.fail_cnt), 1);
    enter(4'b1011, 4'b0100, 1'b1, "t5 good");
    wait_idle("t5 good");
    check("t5 good fail_cnt", int'(bus.fail_cnt), 0);

    // Reset mid-entry.
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("t6 digit_cnt before reset", int'(bus.digit_cnt), 2);
    reset = 1'b1;
    #1;
    check("t6 reset state", int'(bus.state), 0);
    check("t6 reset digit_cnt", int'(bus.digit_cnt), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset on the fifth clock of OPENING drops Unlock asynchronously.
    expect_ev(EvOpen, 5);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    bus.U = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.U = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.Unlock) found = 1'b1;
    end
    check("t6 Unlock seen", int'(found), 1);
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6 Unlock drops on reset", int'(bus.Unlock), 0);
    check("t6 state after reset", int'(bus.state), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    check("events pending", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
